// File: rtl/cycle_reporter.sv
// rtl/cycle_reporter.sv - buffers negative-weight cycle vertex sequences for HPS readout over Avalon-MM
module cycle_reporter #(
  parameter int DEPTH     = 16,
  parameter int PRED_BITS = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cyc_valid,
  input  logic [PRED_BITS-1:0] cyc_vertex,
  input  logic                 cyc_last,
  input  logic                 chipselect,
  input  logic                 read,
  input  logic                 write,
  input  logic [2:0]           address,
  input  logic [DATA_BITS-1:0] writedata,
  output logic [DATA_BITS-1:0] readdata,
  output logic                 irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [PRED_BITS:0]   mem [DEPTH];
  logic [PW-1:0]        wr_ptr, commit_ptr, rd_ptr, cycles;
  logic [1:0]           state;
  logic                 overflow;

  logic [PW-1:0]        used, avail;
  logic                 full, rd_req, pop_fire, pop_last, clear, accept, commit;
  logic [PRED_BITS:0]   pop_entry;
  logic [DATA_BITS-1:0] rd_val;
  logic                 unused_writedata;

  assign used      = wr_ptr - rd_ptr;
  assign avail     = commit_ptr - rd_ptr;
  assign full      = (used == PW'(DEPTH));
  assign pop_entry = mem[rd_ptr[AW-1:0]];

  assign rd_req   = chipselect && read;
  assign pop_fire = rd_req && (address == 3'd1) && (avail != '0);
  assign pop_last = pop_fire && pop_entry[PRED_BITS];
  assign clear    = chipselect && write && (address == 3'd3) && writedata[0];
  assign accept   = cyc_valid && !clear && (state != DROP) && !full;
  assign commit   = accept && cyc_last;

  assign unused_writedata = ^writedata[DATA_BITS-1:1];

  always_comb begin
    rd_val = '0;
    case (address)
      3'd0: begin
        rd_val[0]          = (avail == '0);
        rd_val[1]          = overflow;
        rd_val[3:2]        = state;
        rd_val[4 +: PW]    = avail;
        rd_val[4+PW +: PW] = cycles;
      end
      3'd1: if (avail != '0) rd_val[PRED_BITS+1:0] = {1'b1, pop_entry};
      3'd2: rd_val[PW-1:0] = cycles;
      default: rd_val = '0;
    endcase
  end

  // Storage carries no reset; contents are only visible through committed pointers.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= {cyc_last, cyc_vertex};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      cycles     <= '0;
      state      <= IDLE;
      overflow   <= 1'b0;
      readdata   <= '0;
      irq        <= 1'b0;
    end else begin
      if (rd_req) readdata <= rd_val;
      irq <= (cycles != '0);
      if (clear) begin
        wr_ptr     <= '0;
        commit_ptr <= '0;
        rd_ptr     <= '0;
        cycles     <= '0;
        overflow   <= 1'b0;
        // The producer is mid-cycle: swallow its tail so no fragment is stored.
        state      <= ((state == FILL) || (cyc_valid && !cyc_last)) ? DROP : IDLE;
      end else begin
        if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
        cycles <= cycles + PW'(commit) - PW'(pop_last);
        if (cyc_valid) begin
          if (state == DROP) begin
            if (cyc_last) state <= IDLE;
          end else if (!full) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (cyc_last) begin
              commit_ptr <= wr_ptr + 1'b1;
              state      <= IDLE;
            end else begin
              state      <= FILL;
            end
          end else begin
            wr_ptr   <= commit_ptr;
            overflow <= 1'b1;
            state    <= cyc_last ? IDLE : DROP;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cycle_reporter.sv
// tb/tb_cycle_reporter.sv - directed self-checking bench for cycle_reporter
module tb_cycle_reporter;

  logic        clk;
  logic        reset_n;
  logic        cyc_valid;
  logic [7:0]  cyc_vertex;
  logic        cyc_last;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int tests = 0;
  int fails = 0;
  logic [31:0] d;

  cycle_reporter #(.DEPTH(16), .PRED_BITS(8), .DATA_BITS(32)) dut (
    .clk(clk), .reset_n(reset_n), .cyc_valid(cyc_valid), .cyc_vertex(cyc_vertex),
    .cyc_last(cyc_last), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] v, input logic l);
    cyc_valid = 1'b1; cyc_vertex = v; cyc_last = l;
    tick();
    cyc_valid = 1'b0; cyc_last = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] data);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    data = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] data);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = data;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cyc_valid = 1'b0; cyc_vertex = '0; cyc_last = 1'b0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    tick(); tick();
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick();
    rd(3'd0, d); chk("status_empty", d, 32'h1);
    chk("irq_empty", {31'b0, irq}, 32'h0);
    rd(3'd1, d); chk("pop_empty", d, 32'h0);

    // Cycle 3,7,5
    beat(8'd3, 1'b0); beat(8'd7, 1'b0); beat(8'd5, 1'b1);
    chk("irq_one_after_last", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_two_after_last", {31'b0, irq}, 32'h1);
    rd(3'd2, d); chk("cycles_1", d, 32'h1);
    rd(3'd0, d); chk("status_3_avail", d, 32'h230);
    rd(3'd1, d); chk("pop_3", d, 32'h203);
    rd(3'd1, d); chk("pop_7", d, 32'h207);
    rd(3'd1, d); chk("pop_5_last", d, 32'h305);
    rd(3'd1, d); chk("pop_after_drain", d, 32'h0);
    chk("irq_fell", {31'b0, irq}, 32'h0);

    // Uncommitted beats are invisible
    beat(8'd2, 1'b0); beat(8'd4, 1'b0);
    rd(3'd1, d); chk("pop_uncommitted", d, 32'h0);
    rd(3'd0, d); chk("status_fill", d, 32'h5);
    beat(8'd6, 1'b1);
    rd(3'd1, d); chk("pop_2", d, 32'h202);
    rd(3'd1, d); chk("pop_4", d, 32'h204);
    rd(3'd1, d); chk("pop_6", d, 32'h306);
    rd(3'd1, d); chk("pop_empty_2", d, 32'h0);

    // Overflow: 10-beat cycle, then a 10-beat cycle overflowing at beat 7
    for (int i = 1; i <= 10; i++) beat(8'(i), i == 10);
    for (int i = 1; i <= 7; i++) beat(8'(8'h40 + i), 1'b0);
    rd(3'd0, d); chk("status_drop", d, 32'h2AA);
    for (int i = 8; i <= 10; i++) beat(8'(8'h40 + i), i == 10);
    rd(3'd0, d); chk("status_after_drop", d, 32'h2A2);
    for (int i = 1; i <= 3; i++) beat(8'(8'h60 + i), i == 3);
    rd(3'd0, d); chk("status_13_avail", d, 32'h4D2);
    rd(3'd1, d); chk("pop_first_kept", d, 32'h201);

    // CLEAR mid-cycle
    beat(8'h71, 1'b0); beat(8'h72, 1'b0);
    wr(3'd3, 32'h1);
    rd(3'd0, d); chk("status_clear_drop", d, 32'h9);
    beat(8'h73, 1'b0); beat(8'h74, 1'b1);
    rd(3'd0, d); chk("status_clear_idle", d, 32'h1);
    beat(8'd9, 1'b0); beat(8'd10, 1'b1);
    rd(3'd1, d); chk("pop_after_clear_a", d, 32'h209);
    rd(3'd1, d); chk("pop_after_clear_b", d, 32'h30A);
    tick();

    // Same-cycle POP of last entry and commit of a new cycle
    beat(8'h11, 1'b1);
    tick();
    beat(8'h21, 1'b0);
    cyc_valid = 1'b1; cyc_vertex = 8'h22; cyc_last = 1'b1;
    chipselect = 1'b1; read = 1'b1; address = 3'd1;
    tick();
    cyc_valid = 1'b0; cyc_last = 1'b0; chipselect = 1'b0; read = 1'b0;
    chk("pop_concurrent", readdata, 32'h311);
    chk("irq_concurrent", {31'b0, irq}, 32'h1);
    rd(3'd2, d); chk("cycles_concurrent", d, 32'h1);
    chk("irq_stays", {31'b0, irq}, 32'h1);

    // Reset mid-FILL
    beat(8'h33, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midreset_readdata", readdata, 32'h0);
    chk("midreset_irq", {31'b0, irq}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    rd(3'd0, d); chk("status_post_reset", d, 32'h1);
    beat(8'h44, 1'b1);
    rd(3'd1, d); chk("pop_post_reset", d, 32'h344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
